// File: rtl/ahb_lite_decoder_mux.sv
// rtl/ahb_lite_decoder_mux.sv - AHB-Lite address decoder, data-phase response mux and error tracker
module ahb_lite_decoder_mux #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_BASE =
    {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_MASK = {4{32'hF000_0000}}
) (
  input  logic                             HCLK,
  input  logic                             HRESETn,
  input  logic [ADDR_WIDTH-1:0]            HADDR,
  input  logic [1:0]                       HTRANS,
  output logic [NUM_SLAVES-1:0]            HSEL_S,
  output logic                             HSEL_DEF,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_S,
  input  logic [NUM_SLAVES*2-1:0]          HRESP_S,
  input  logic [NUM_SLAVES-1:0]            HREADYOUT_S,
  input  logic [DATA_WIDTH-1:0]            HRDATA_DEF,
  input  logic [1:0]                       HRESP_DEF,
  input  logic                             HREADYOUT_DEF,
  output logic [DATA_WIDTH-1:0]            HRDATA,
  output logic [1:0]                       HRESP,
  output logic                             HREADY,
  output logic [15:0]                      ERR_CNT,
  output logic [ADDR_WIDTH-1:0]            ERR_ADDR
);

  // Owner encoding: 0..NUM_SLAVES-1 are mapped subordinates, then default, then no owner
  localparam int              OWN_W      = $clog2(NUM_SLAVES + 2);
  localparam logic [OWN_W-1:0] OWN_DEF   = OWN_W'(NUM_SLAVES);
  localparam logic [OWN_W-1:0] OWN_NONE  = OWN_W'(NUM_SLAVES + 1);
  localparam logic [1:0]       RESP_ERROR = 2'b01;

  logic [OWN_W-1:0]      r_own;
  logic [ADDR_WIDTH-1:0] r_addr_q;
  logic [ADDR_WIDTH-1:0] r_err_addr;
  logic [15:0]           r_err_cnt;

  logic [OWN_W-1:0]      w_dec_tgt;
  logic                  w_active;
  logic                  w_err_evt;

  // NONSEQ or SEQ; IDLE and BUSY carry no transfer
  assign w_active = (HTRANS == 2'b10) || (HTRANS == 2'b11);

  // Address decode: scan downward so the lowest matching index overrides higher ones
  always_comb begin
    w_dec_tgt = OWN_DEF;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((HADDR & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        w_dec_tgt = OWN_W'(i);
      end
    end
  end

  // One-hot selects, only asserted during an active address phase
  always_comb begin
    HSEL_S = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      HSEL_S[i] = w_active && (w_dec_tgt == OWN_W'(i));
    end
    HSEL_DEF = w_active && (w_dec_tgt == OWN_DEF);
  end

  // Data-phase response mux; with no owner the manager sees a zero-wait OKAY
  always_comb begin
    HRDATA = '0;
    HRESP  = 2'b00;
    HREADY = 1'b1;
    if (r_own == OWN_DEF) begin
      HRDATA = HRDATA_DEF;
      HRESP  = HRESP_DEF;
      HREADY = HREADYOUT_DEF;
    end
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_own == OWN_W'(i)) begin
        HRDATA = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
        HRESP  = HRESP_S[i*2 +: 2];
        HREADY = HREADYOUT_S[i];
      end
    end
  end

  // First cycle of a two-cycle ERROR; a subordinate stuck there is counted every cycle
  assign w_err_evt = (HRESP == RESP_ERROR) && !HREADY;

  // Owner and data-phase address advance only when the current data phase completes
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_own    <= OWN_NONE;
      r_addr_q <= '0;
    end else if (HREADY) begin
      r_own    <= w_active ? w_dec_tgt : OWN_NONE;
      r_addr_q <= HADDR;
    end
  end

  // Error debug: saturating counter and address of the latest ERROR transfer
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_err_cnt  <= '0;
      r_err_addr <= '0;
    end else if (w_err_evt) begin
      r_err_addr <= r_addr_q;
      if (r_err_cnt != 16'hFFFF) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  assign ERR_CNT  = r_err_cnt;
  assign ERR_ADDR = r_err_addr;

endmodule

// File: doc/ahb_lite_decoder_mux.md
Name: ahb_lite_decoder_mux

Overview:
AHB-Lite address decoder and response multiplexer between the single manager and the subordinates, including the default subordinate that covers unmapped space. In the address phase it decodes HADDR into one-hot subordinate selects. It holds a registered data-phase owner so it can route HRDATA, HRESP and HREADY back to the manager and to all subordinates. It also keeps a saturating count and the address of the most recent ERROR response for debug.

Parameters:
ADDR_WIDTH, 32, address bus width
DATA_WIDTH, 32, data bus width
NUM_SLAVES, 4, number of mapped subordinates; the default subordinate is extra
SLV_BASE, {32'h3000_0000,32'h2000_0000,32'h1000_0000,32'h0000_0000}, packed base per subordinate; index 0 in the LSBs
SLV_MASK, {4{32'hF000_0000}}, packed decode mask per subordinate

Ports:
HCLK  in  1  clock
HRESETn  in  1  asynchronous active-low reset
HADDR  in  ADDR_WIDTH  manager address
HTRANS  in  2  manager transfer type
HSEL_S  out  NUM_SLAVES  one-hot subordinate selects
HSEL_DEF  out  1  default subordinate select
HRDATA_S  in  NUM_SLAVES*DATA_WIDTH  packed subordinate read data
HRESP_S  in  NUM_SLAVES*2  packed subordinate responses; 2'b00 OKAY, 2'b01 ERROR
HREADYOUT_S  in  NUM_SLAVES  packed subordinate ready
HRDATA_DEF  in  DATA_WIDTH  default subordinate read data
HRESP_DEF  in  2  default subordinate response
HREADYOUT_DEF  in  1  default subordinate ready
HRDATA  out  DATA_WIDTH  muxed read data to the manager
HRESP  out  2  muxed response to the manager
HREADY  out  1  muxed ready, fed to the manager and as HREADYin to every subordinate
ERR_CNT  out  16  saturating count of ERROR responses
ERR_ADDR  out  ADDR_WIDTH  address of the most recent ERROR transfer

Behaviour:
- Decode (combinational):
  - match_i = ((HADDR & SLV_MASK[i]) == SLV_BASE[i]).
  - If several subordinates match, the lowest index wins.
  - If none match, the default subordinate is selected.
- Selects are qualified by HTRANS[1]. For IDLE or BUSY, all of HSEL_S and HSEL_DEF are 0.
- Data-phase owner register `own`. It has NUM_SLAVES+2 states: S0..S(N-1), DEF, NONE.
  - It updates on posedge HCLK only when HREADY=1.
  - On update it loads the decoded target if HTRANS[1]=1, otherwise NONE.
  - When HREADY=0 it holds, so a 2-cycle ERROR or any wait-state sequence completes on the same owner.
- Address register `addr_q` loads HADDR under the same condition as `own`, so it holds the data-phase address.
- Output mux (combinational from `own`):
  - Owner Si: HRDATA, HRESP and HREADY come from subordinate i.
  - Owner DEF: HRDATA, HRESP and HREADY come from the default subordinate.
  - Owner NONE: HRDATA=0, HRESP=2'b00, HREADY=1 (zero-wait OKAY).
- Error tracking:
  - A response is counted on a cycle where HRESP==2'b01 and HREADY==0 (first cycle of the two-cycle ERROR), so each ERROR counts exactly once.
  - On that cycle ERR_ADDR <= addr_q and ERR_CNT <= ERR_CNT+1, saturating at 16'hFFFF.
  - A subordinate that violates the protocol and holds ERROR with HREADY=0 for k cycles is counted k times. This is intentional; the verifier must check for it.
- Reset (asynchronous, HRESETn low):
  - own=NONE, addr_q=0, ERR_CNT=0, ERR_ADDR=0.
  - The outputs therefore go immediately to HRDATA=0, HRESP=00, HREADY=1. Selects follow the inputs combinationally.
  - Reset in the middle of a wait-stated transfer abandons it. The first post-reset cycle is a NONE data phase.
- Latency: selects are the same cycle as the address; response routing is 1 cycle after the accepted address phase. No added wait states.
- HRESP values other than 00 and 01 are passed through unchanged and are not counted.

Test Plan:
- Reset: HRESETn low with HTRANS=NONSEQ, HADDR=0x1000_0004 -> HREADY=1, HRESP=00, HRDATA=0, ERR_CNT=0. HSEL_S=4'b0010 combinationally.
- Decode and route:
  - NONSEQ to 0x2000_0010 -> HSEL_S=4'b0100 in the address cycle.
  - Next cycle, subordinate 2 drives HRDATA=0xCAFE_F00D with HREADYOUT=1 -> HRDATA=0xCAFE_F00D and HREADY=1.
- Wait states: subordinate 1 holds HREADYOUT=0 for 3 cycles while the manager presents the next NONSEQ to 0x0000_0000 -> `own` stays S1 for all 3 cycles and HSEL_S=4'b0001 is held. On the 4th cycle the owner moves to S0.
- Unmapped address: NONSEQ to 0x8000_0000 -> HSEL_DEF=1. The default subordinate drives a 2-cycle ERROR (01/0 then 01/1) -> HRESP=01 on both cycles, ERR_CNT=1, ERR_ADDR=0x8000_0000.
- IDLE: HTRANS=IDLE at 0x8000_0000 -> no select asserted and the next cycle is a NONE data phase (HREADY=1, OKAY). Back-to-back NONSEQ via HTRANS=SEQ still routes each beat.
- Saturation: force ERR_CNT to 16'hFFFE, then issue 3 ERROR transfers -> ERR_CNT reads FFFF and stays there. ERR_ADDR shows the last erroring address.
